// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Build option: UART_RX_PARITY_EN adds the PARITY state to rx_state_t.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 7;
    localparam logic        IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StRecover
    } rx_state_t;

endpackage

// File: rtl/uart_rx_parity_checker_if.sv
// Bundles the line-side inputs and the host-side results of the UART receiver.
interface uart_rx_parity_checker_if #(
    parameter int unsigned size = 4
);
    logic            baud_tick;
    logic            rx;
    logic [size-1:0] rx_data;
    logic            rx_valid;
    logic            parity_err;
    logic            frame_err;
    logic            busy;

    modport master (
        input  baud_tick, rx,
        output rx_data, rx_valid, parity_err, frame_err, busy
    );

    modport slave (
        output baud_tick, rx,
        input  rx_data, rx_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line; resets to the idle line level.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    // Two-stage capture of the raw line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= IDLE_LEVEL;
            q    <= IDLE_LEVEL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_parity_checker.sv
// UART receiver: 16x oversampled frame recovery with even-parity and stop-bit checks.
// Build option: UART_RX_PARITY_EN enables the parity bit after the data bits;
// without it parity_err is tied to 0.
module uart_rx_parity_checker
    import uart_pkg::*;
#(
    parameter int unsigned size = 4
) (
    input logic                      clk,
    input logic                      rst_n,
    uart_rx_parity_checker_if.master bus
);
    localparam logic [3:0] LastTick = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MidTick  = 4'(MID_SAMPLE);
    localparam logic [3:0] LastBit  = 4'(size - 1);

    rx_state_t       state_q, state_d;
    logic            rx_s;
    logic [3:0]      tick_cnt_q;
    logic [3:0]      bit_idx_q;
    logic [size-1:0] shift_q;
    logic            perr;
    logic [size-1:0] rx_data_q;
    logic            rx_valid_q, parity_err_q, frame_err_q;
    logic            mid_bit, cnt_clr, cnt_inc, data_smp, stop_smp, busy;
`ifdef UART_RX_PARITY_EN
    logic            par_smp;
`endif

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.rx),
        .q     (rx_s)
    );

    // A tick on which the oversample counter wraps marks the middle of a bit.
    assign mid_bit = bus.baud_tick && (tick_cnt_q == LastTick);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (bus.baud_tick && !rx_s) state_d = StStart;
            StStart: begin
                if (bus.baud_tick && tick_cnt_q == MidTick) begin
                    state_d = (rx_s == IDLE_LEVEL) ? StIdle : StData;
                end
            end
            StData: begin
                if (mid_bit && bit_idx_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity:  if (mid_bit) state_d = StStop;
`endif
            // A low stop bit may be a break; wait for the line to return high.
            StStop:    if (mid_bit) state_d = (rx_s == IDLE_LEVEL) ? StIdle : StRecover;
            StRecover: if (bus.baud_tick && rx_s) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Per-state datapath strobes.
    always_comb begin
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        data_smp = 1'b0;
        stop_smp = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_smp  = 1'b0;
`endif
        busy     = (state_q != StIdle);
        unique case (state_q)
            StIdle:  cnt_clr = bus.baud_tick && !rx_s;
            StStart: begin
                if (bus.baud_tick) begin
                    if (tick_cnt_q == MidTick) cnt_clr = 1'b1;
                    else                       cnt_inc = 1'b1;
                end
            end
            StData: begin
                cnt_inc  = bus.baud_tick;
                data_smp = mid_bit;
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                cnt_inc = bus.baud_tick;
                par_smp = mid_bit;
            end
`endif
            StStop: begin
                cnt_inc  = bus.baud_tick;
                stop_smp = mid_bit;
            end
            default: ;
        endcase
    end

    // Counters, shift register and the held result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q   <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            if (cnt_clr)      tick_cnt_q <= '0;
            else if (cnt_inc) tick_cnt_q <= tick_cnt_q + 4'd1;

            if (cnt_clr)       bit_idx_q <= '0;
            else if (data_smp) bit_idx_q <= bit_idx_q + 4'd1;

            if (data_smp) begin
                for (int i = 0; i < int'(size); i++) begin
                    if (bit_idx_q == 4'(i)) shift_q[i] <= rx_s;
                end
            end

            rx_valid_q <= stop_smp;
            if (stop_smp) begin
                rx_data_q    <= shift_q;
                parity_err_q <= perr;
                frame_err_q  <= ~rx_s;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the received parity bit must equal the XOR of the data bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       perr <= 1'b0;
        else if (par_smp) perr <= rx_s ^ (^shift_q);
    end
`else
    assign perr = 1'b0;
`endif

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = busy;
endmodule

// File: tb/tb_uart_rx_parity_checker.sv
// Self-checking bench for uart_rx_parity_checker (size = 4). Works with or without
// UART_RX_PARITY_EN; the frame format follows the macro.
module tb_uart_rx_parity_checker;

    typedef struct {
        logic [3:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] tick_div = 2'd0;

    int n_checks = 0;
    int n_err    = 0;
    int n_valid  = 0;
    int n_frames = 0;
    exp_t exp_q[$];
    exp_t hold = '{data: 4'h0, perr: 1'b0, ferr: 1'b0};
    logic prev_valid = 1'b0;

    uart_rx_parity_checker_if #(.size(4)) bus ();

    uart_rx_parity_checker #(.size(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // One baud tick every 4 clocks.
    initial bus.baud_tick = 1'b0;
    always @(negedge clk) begin
        tick_div      = tick_div + 2'd1;
        bus.baud_tick = (tick_div == 2'd3);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Hold the line at v for n baud ticks.
    task automatic line(input logic v, input int n);
        bus.rx = v;
        repeat (n * 4) @(negedge clk);
    endtask

    // Send one frame; expected result is derived from the frame rules and queued.
    task automatic send_frame(input logic [3:0] d, input logic par_bad, input logic stop_v);
        exp_t e;
        line(1'b0, 16);
        for (int i = 0; i < 4; i++) line(d[i], 16);
`ifdef UART_RX_PARITY_EN
        line((^d) ^ par_bad, 16);
        e.perr = par_bad;
`else
        e.perr = 1'b0;
`endif
        e.data = d;
        e.ferr = !stop_v;
        exp_q.push_back(e);
        n_frames++;
        line(stop_v, 16);
    endtask

    // Cycle-by-cycle comparison against the expected-result queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold       = '{data: 4'h0, perr: 1'b0, ferr: 1'b0};
            prev_valid = 1'b0;
            check("valid_in_reset", int'(bus.rx_valid), 0);
        end else begin
            if (bus.rx_valid) begin
                n_valid++;
                check("valid_width", int'(prev_valid), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("data", int'(bus.rx_data), int'(e.data));
                    check("parity_err", int'(bus.parity_err), int'(e.perr));
                    check("frame_err", int'(bus.frame_err), int'(e.ferr));
                    hold = e;
                end
            end else begin
                check("hold_data", int'(bus.rx_data), int'(hold.data));
                check("hold_parity_err", int'(bus.parity_err), int'(hold.perr));
                check("hold_frame_err", int'(bus.frame_err), int'(hold.ferr));
            end
            prev_valid = bus.rx_valid;
        end
    end

    initial begin
        int v0;
        logic [3:0] d;
        logic pb, sv;

        bus.rx = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_data", int'(bus.rx_data), 0);
        check("rst_valid", int'(bus.rx_valid), 0);
        check("rst_parity_err", int'(bus.parity_err), 0);
        check("rst_frame_err", int'(bus.frame_err), 0);
        check("rst_busy", int'(bus.busy), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        line(1'b1, 4);

        // Good frame 1011.
        v0 = n_valid;
        send_frame(4'hB, 1'b0, 1'b1);
        line(1'b1, 4);
        check("b_count", n_valid - v0, 1);
        check("b_data", int'(bus.rx_data), 11);
        check("b_perr", int'(bus.parity_err), 0);
        check("b_ferr", int'(bus.frame_err), 0);
        check("b_busy", int'(bus.busy), 0);

`ifdef UART_RX_PARITY_EN
        // Same data, parity bit sent as 0.
        v0 = n_valid;
        send_frame(4'hB, 1'b1, 1'b1);
        line(1'b1, 4);
        check("bp_count", n_valid - v0, 1);
        check("bp_data", int'(bus.rx_data), 11);
        check("bp_perr", int'(bus.parity_err), 1);
`endif

        // Low stop bit followed by a 3-bit-time break.
        v0 = n_valid;
        send_frame(4'h5, 1'b0, 1'b0);
        line(1'b0, 48);
        check("brk_ferr", int'(bus.frame_err), 1);
        check("brk_data", int'(bus.rx_data), 5);
        check("brk_busy_recover", int'(bus.busy), 1);
        line(1'b1, 3);
        check("brk_busy_idle", int'(bus.busy), 0);
        check("brk_count", n_valid - v0, 1);
        line(1'b1, 10);

        // 4-tick glitch: false start.
        v0 = n_valid;
        line(1'b0, 3);
        check("glitch_busy_seen", int'(bus.busy), 1);
        line(1'b0, 1);
        line(1'b1, 8);
        check("glitch_busy_gone", int'(bus.busy), 0);
        line(1'b1, 10);
        check("glitch_count", n_valid - v0, 0);

        // Reset during the second data bit of 1010.
        v0 = n_valid;
        line(1'b0, 16);
        line(1'b0, 16);
        line(1'b1, 8);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_data", int'(bus.rx_data), 0);
        check("mid_rst_valid", int'(bus.rx_valid), 0);
        check("mid_rst_perr", int'(bus.parity_err), 0);
        check("mid_rst_ferr", int'(bus.frame_err), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        bus.rx = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        line(1'b1, 5);
        check("mid_rst_count", n_valid - v0, 0);
        send_frame(4'h3, 1'b0, 1'b1);
        line(1'b1, 4);
        check("after_rst_data", int'(bus.rx_data), 3);
        check("after_rst_count", n_valid - v0, 1);

        // Back-to-back frames.
        v0 = n_valid;
        send_frame(4'h1, 1'b0, 1'b1);
        send_frame(4'hF, 1'b0, 1'b1);
        line(1'b1, 4);
        check("b2b_count", n_valid - v0, 2);
        check("b2b_data", int'(bus.rx_data), 15);
        check("b2b_perr", int'(bus.parity_err), 0);

        // Random frames with random corruption and gaps.
        for (int k = 0; k < 30; k++) begin
            d  = 4'($urandom_range(0, 15));
            pb = ($urandom_range(0, 3) == 0);
            sv = ($urandom_range(0, 4) != 0);
            send_frame(d, pb, sv);
            if (!sv) begin
                line(1'b0, int'($urandom_range(0, 40)));
                line(1'b1, 3 + int'($urandom_range(0, 20)));
            end else begin
                line(1'b1, int'($urandom_range(0, 20)));
            end
        end
        line(1'b1, 20);

        check("queue_drained", exp_q.size(), 0);
        check("total_valid", n_valid, n_frames);
        check("final_busy", int'(bus.busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
